gate_tt_checker: RTL and testbench
==================================

Name: gate_tt_checker

Overview:
- Self-checking truth-table sequencer that sits on both sides of a combinational gate.
- Upstream, it drives every input combination onto the gate inputs.
- Downstream, it samples the gate output after a programmable settle time and compares it with an expected truth table.
- Used on-board and in regression to qualify the small gate blocks (and_gate and its siblings) without a hand-written testbench per gate.

Parameters:
- N_IN, 2, number of gate inputs; sweeps 2**N_IN vectors (1..6 supported)
- SETTLE, 2, idle cycles after each new vector before sampling (0..15)
- TRUTH, 4'b1000, expected output; bit k = expected gate_out for input vector k (width 2**N_IN); default is 2-input AND

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request a sweep; sampled only in IDLE
- gate_out  in  1  output of gate under test
- gate_in  out  N_IN  input vector driven to gate under test
- busy  out  1  high while a sweep is running
- done  out  1  one-cycle pulse when a sweep completes
- pass  out  1  high when the last sweep had zero mismatches
- err_count  out  N_IN+1  mismatch count of the last sweep
- first_fail  out  N_IN  vector index of the first mismatch in the last sweep
- fail_valid  out  1  first_fail holds a valid index

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset: on rst_n=0, all outputs go to 0 immediately and the state goes to IDLE. pass=0 after reset.
- FSM states: IDLE, DRIVE, DONE.
  - IDLE: gate_in=0, busy=0.
  - IDLE -> DRIVE: start=1 at a rising edge (call it E0). On E0: index=0, settle counter=0, err_count=0, fail_valid=0, first_fail=0, busy=1.
  - DRIVE: gate_in=index. Each vector is held for SETTLE+1 cycles.
  - Sampling: on the last edge of a vector's hold, i.e. E0+(k+1)*(SETTLE+1), gate_out is compared with TRUTH[k].
  - Mismatch: err_count increments. If fail_valid=0, first_fail<=k and fail_valid<=1.
  - Last vector: if k == 2**N_IN-1, go to DONE on that same edge; otherwise index increments and the settle counter clears.
  - DONE: lasts exactly one cycle. done=1, busy=0, pass=(err_count==0), gate_in=0. Then go to IDLE.
  - Latency: done is high in the cycle after edge E0+2**N_IN*(SETTLE+1).
  - N_IN=2, SETTLE=2: done is high after edge E0+12.
- Result hold: err_count, pass, first_fail and fail_valid hold until the next accepted start.
  - At start they clear, except pass, which holds its old value until the next DONE.
- Width: err_count never overflows, since its max value 2**N_IN fits in N_IN+1 bits. No saturation logic.
- start while busy or in DONE: ignored; no queueing. A start held high through DONE is accepted on the first IDLE edge.
- Reset mid-sweep: aborts immediately with no done pulse. All results are cleared.
- gate_out is treated as a 2-state value. X handling is not specified for RTL.

Decomposition:
- Shared package gate_chk_pkg:
  - state encoding constants ST_IDLE=2'd0, ST_DRIVE=2'd1, ST_DONE=2'd2
  - default TRUTH constants for the family: AND2=4'b1000, OR2=4'b1110, XOR2=4'b0110, NAND2=4'b0111
- One sub-module: settle_timer (counter 0..SETTLE, clear input, terminal-count output).
- Index, compare and result registers stay in the top.

Test Plan:
- Default params, and_gate as DUT, start pulse at E0: gate_in steps 00,01,10,11 every 3 cycles; done pulses after E0+12; pass=1, err_count=0, fail_valid=0.
- TRUTH=AND2 with an OR gate as DUT: err_count=2, first_fail=01, fail_valid=1, pass=0.
- gate_out tied to 1: err_count=3, first_fail=00, pass=0. Tied to 0: err_count=1, first_fail=11.
- start pulsed again at E0+5 and held through DONE: second pulse ignored mid-sweep; the held start launches a new sweep on the IDLE edge after done, and results clear at that edge.
- rst_n low at E0+7 for 2 cycles: outputs 0 asynchronously, no done pulse; a fresh start then completes a normal 12-cycle sweep.
- SETTLE=0, N_IN=3, TRUTH=8'b1000_0000 with a 3-input AND: vector changes every cycle; done after E0+8, pass=1.

Source files
------------

// File: rtl/gate_chk_pkg.sv
// gate_chk_pkg: state encoding and reference truth tables shared by the gate checker family
package gate_chk_pkg;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_DRIVE = 2'd1, ST_DONE = 2'd2} state_t;
  localparam logic [3:0] AND2  = 4'b1000;
  localparam logic [3:0] OR2   = 4'b1110;
  localparam logic [3:0] XOR2  = 4'b0110;
  localparam logic [3:0] NAND2 = 4'b0111;
endpackage

// File: rtl/gate_tt_checker_settle_timer.sv
// settle_timer: counts 0..SETTLE, tc flags the final cycle of a vector's hold
module settle_timer #(
  parameter int SETTLE = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tc
);
  localparam int W = SETTLE > 0 ? $clog2(SETTLE + 1) : 1;
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else cnt <= clr ? '0 : cnt + 1'b1;
  end
  assign tc = cnt == W'(SETTLE);
endmodule

// File: rtl/gate_tt_checker.sv
// gate_tt_checker: sweeps all input vectors through a gate and scores its output against TRUTH
module gate_tt_checker import gate_chk_pkg::*; #(
  parameter int N_IN = 2,
  parameter int SETTLE = 2,
  parameter logic [(1<<N_IN)-1:0] TRUTH = AND2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            gate_out,
  output logic [N_IN-1:0] gate_in,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic [N_IN-1:0] first_fail,
  output logic            fail_valid
);
  localparam logic [N_IN-1:0] LAST = N_IN'((1 << N_IN) - 1);
  localparam int EW = N_IN + 1;
  state_t state;
  logic tc, mis;
  logic [N_IN:0] err_next;
  settle_timer #(.SETTLE(SETTLE)) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (state != ST_DRIVE || tc),
    .tc   (tc)
  );
  // gate_in doubles as the vector index; it reads 0 outside DRIVE
  assign mis = gate_out != TRUTH[gate_in];
  assign err_next = err_count + EW'(mis);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      gate_in    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      first_fail <= '0;
      fail_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          state      <= ST_DRIVE;
          gate_in    <= '0;
          busy       <= 1'b1;
          err_count  <= '0;
          first_fail <= '0;
          fail_valid <= 1'b0;
        end
        ST_DRIVE: if (tc) begin
          err_count <= err_next;
          if (mis && !fail_valid) begin
            first_fail <= gate_in;
            fail_valid <= 1'b1;
          end
          if (gate_in == LAST) begin
            state   <= ST_DONE;
            gate_in <= '0;
            busy    <= 1'b0;
            done    <= 1'b1;
            pass    <= err_next == '0;
          end else begin
            gate_in <= gate_in + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          done  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_gate_tt_checker.sv
// tb_gate_tt_checker: two checker configurations scored against a cycle-level behavioural model
module tb_gate_tt_checker;
  import gate_chk_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [7:0] act [2];
  logic [7:0] truth [2];
  logic g0, g1;
  logic [1:0] gi0, ff0;
  logic [2:0] err0, gi1, ff1;
  logic [3:0] err1;
  logic busy0, done0, pass0, fv0, busy1, done1, pass1, fv1;
  int n_cmp = 0, n_bad = 0;
  int nv [2] = '{4, 8};
  int sp1 [2] = '{3, 1};
  int m_st [2], m_e [2], m_err [2], m_ff [2], m_fv [2], m_pass [2];

  always #5 clk = ~clk;
  assign g0 = act[0][gi0];
  assign g1 = act[1][gi1];

  gate_tt_checker u0 (
    .clk(clk), .rst_n(rst_n), .start(start), .gate_out(g0), .gate_in(gi0), .busy(busy0),
    .done(done0), .pass(pass0), .err_count(err0), .first_fail(ff0), .fail_valid(fv0)
  );
  gate_tt_checker #(.N_IN(3), .SETTLE(0), .TRUTH(8'b1000_0000)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start), .gate_out(g1), .gate_in(gi1), .busy(busy1),
    .done(done1), .pass(pass1), .err_count(err1), .first_fail(ff1), .fail_valid(fv1)
  );

  task automatic chk(input string name, input int d, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s dut%0d @%0t: got %0d expected %0d", name, d, $time, got, exp);
    end
  endtask

  // model: m_e counts edges since the accepting edge; a vector is scored every sp1 edges
  always @(posedge clk) begin
    int k;
    #1;
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        m_st[d] = 0; m_e[d] = 0; m_err[d] = 0; m_ff[d] = 0; m_fv[d] = 0; m_pass[d] = 0;
      end else if (m_st[d] == 0) begin
        if (start) begin
          m_st[d] = 1; m_e[d] = 0; m_err[d] = 0; m_ff[d] = 0; m_fv[d] = 0;
        end
      end else if (m_st[d] == 2) begin
        m_st[d] = 0;
      end else begin
        m_e[d]++;
        if (m_e[d] % sp1[d] == 0) begin
          k = m_e[d] / sp1[d] - 1;
          if (act[d][k] != truth[d][k]) begin
            m_err[d]++;
            if (m_fv[d] == 0) begin m_ff[d] = k; m_fv[d] = 1; end
          end
          if (k == nv[d] - 1) begin m_st[d] = 2; m_pass[d] = (m_err[d] == 0) ? 1 : 0; end
        end
      end
      chk("gate_in", d, d ? int'(gi1) : int'(gi0), m_st[d] == 1 ? m_e[d] / sp1[d] : 0);
      chk("busy", d, d ? int'(busy1) : int'(busy0), m_st[d] == 1 ? 1 : 0);
      chk("done", d, d ? int'(done1) : int'(done0), m_st[d] == 2 ? 1 : 0);
      chk("pass", d, d ? int'(pass1) : int'(pass0), m_pass[d]);
      chk("err_count", d, d ? int'(err1) : int'(err0), m_err[d]);
      chk("first_fail", d, d ? int'(ff1) : int'(ff0), m_ff[d]);
      chk("fail_valid", d, d ? int'(fv1) : int'(fv0), m_fv[d]);
    end
  end

  task automatic sweep(input string nm, input int e_err, input int e_ff, input int e_fv, input int e_pass);
    int lat, lat1;
    lat = 0;
    lat1 = -1;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    while (!done0 && lat < 100) begin
      if (done1 && lat1 < 0) lat1 = lat;
      @(negedge clk);
      lat++;
    end
    chk({nm, " latency"}, 0, lat, 12);
    chk({nm, " latency"}, 1, lat1, 8);
    chk({nm, " err_count"}, 0, err0, e_err);
    chk({nm, " first_fail"}, 0, ff0, e_ff);
    chk({nm, " fail_valid"}, 0, fv0, e_fv);
    chk({nm, " pass"}, 0, pass0, e_pass);
    chk({nm, " pass"}, 1, pass1, act[1] == 8'h80 ? 1 : 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int lat;
    truth[0] = 8'h08;
    truth[1] = 8'h80;
    act[0] = 8'h08;
    act[1] = 8'h80;
    for (int d = 0; d < 2; d++) begin
      m_st[d] = 0; m_e[d] = 0; m_err[d] = 0; m_ff[d] = 0; m_fv[d] = 0; m_pass[d] = 0;
    end
    repeat (2) @(negedge clk);
    chk("reset pass", 0, pass0, 0);
    chk("reset busy", 0, busy0, 0);
    chk("reset gate_in", 1, gi1, 0);
    rst_n = 1'b1;
    @(negedge clk);
    sweep("and", 0, 0, 0, 1);
    act[0] = {4'h0, OR2};
    sweep("or", 2, 1, 1, 0);
    act[0] = 8'h0f;
    sweep("tie1", 3, 0, 1, 0);
    act[0] = 8'h00;
    sweep("tie0", 1, 3, 1, 0);
    // retrigger mid-sweep, then hold start through DONE into the next IDLE edge
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1;
    lat = 4;
    while (!done0 && lat < 100) begin @(negedge clk); lat++; end
    chk("retrig latency", 0, lat, 12);
    chk("retrig err_count", 0, err0, 1);
    @(negedge clk);
    chk("retrig idle busy", 0, busy0, 0);
    @(negedge clk);
    start = 1'b0;
    chk("relaunch busy", 0, busy0, 1);
    chk("relaunch err_count", 0, err0, 0);
    chk("relaunch fail_valid", 0, fv0, 0);
    chk("relaunch pass held", 0, pass0, 0);
    repeat (30) @(negedge clk);
    // asynchronous reset partway through a sweep
    act[0] = 8'h08;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (6) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async busy", 0, busy0, 0);
    chk("async gate_in", 0, gi0, 0);
    chk("async busy", 1, busy1, 0);
    chk("async pass", 1, pass1, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    sweep("post reset", 0, 0, 0, 1);
    for (int it = 0; it < 40; it++) begin
      @(negedge clk);
      act[0] = 8'($urandom);
      act[1] = 8'($urandom);
      start = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) rst_n = 1'b0;
      repeat ($urandom_range(1, 15)) @(negedge clk);
      start = 1'b0;
      rst_n = 1'b1;
      repeat ($urandom_range(0, 20)) @(negedge clk);
    end
    repeat (30) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
